// File: rtl/dma2d_pkg.sv
// Default widths for the 2-D strided address generator, matching the SRAM address and tag sizes.
package dma2d_pkg;
    localparam int AW_DEF  = 11;
    localparam int IFW_DEF = 8;
    localparam int SZW_DEF = 7;
    localparam int STW_DEF = 5;
    localparam int RW_DEF  = 5;
    localparam int RSW_DEF = 11;
endpackage

// File: rtl/dma2d_if.sv
// Command port and beat stream of dma2d. master is the generator side, slave is the requester/consumer side.
interface dma2d_if
    import dma2d_pkg::*;
#(
    parameter int AW  = AW_DEF,
    parameter int IFW = IFW_DEF,
    parameter int SZW = SZW_DEF,
    parameter int STW = STW_DEF,
    parameter int RW  = RW_DEF,
    parameter int RSW = RSW_DEF
) ();
    logic [AW-1:0]  base;
    logic [SZW-1:0] size;
    logic [STW-1:0] step;
    logic [RW-1:0]  rows;
    logic [RSW-1:0] row_stride;
    logic [IFW-1:0] info;
    logic           start_valid;
    logic           start_ready;
    logic [AW-1:0]  s_addr;
    logic [IFW-1:0] s_info;
    logic           s_first;
    logic           s_row_last;
    logic           s_last;
    logic           s_valid;
    logic           s_ready;
    logic           busy;

    modport master (
        input  base, size, step, rows, row_stride, info, start_valid, s_ready,
        output start_ready, s_addr, s_info, s_first, s_row_last, s_last, s_valid, busy
    );

    modport slave (
        output base, size, step, rows, row_stride, info, start_valid, s_ready,
        input  start_ready, s_addr, s_info, s_first, s_row_last, s_last, s_valid, busy
    );
endinterface

// File: rtl/dma_loop_cnt.sv
// Loop down-counter with load, decrement and reload-from-shadow; next-is-zero looks at the post-update value.
// Latency: registered count, zero flags combinational; no backpressure of its own (caller gates dec/reload).
module dma_loop_cnt #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    input  logic         reload,
    output logic         zero,
    output logic         nxt_zero
);
    logic [W-1:0] cnt;
    logic [W-1:0] shadow;
    logic [W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (load) begin
            cnt_nxt = load_val;
        end else if (reload) begin
            cnt_nxt = shadow;
        end else if (dec) begin
            cnt_nxt = cnt - W'(1);
        end
    end

    assign zero     = (cnt == '0);
    assign nxt_zero = (cnt_nxt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            shadow <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (load) begin
                shadow <= load_val;
            end
        end
    end
endmodule

// File: rtl/dma2d.sv
// 2-D strided address generator: one command in, (size+1)*(rows+1) beat addresses out with first/row_last/last marks.
// Latency: first beat the cycle after accept, then one beat/cycle; stalls hold all outputs, next command accepted on the last beat.
module dma2d
    import dma2d_pkg::*;
#(
    parameter int AW  = AW_DEF,
    parameter int IFW = IFW_DEF,
    parameter int SZW = SZW_DEF,
    parameter int STW = STW_DEF,
    parameter int RW  = RW_DEF,
    parameter int RSW = RSW_DEF
) (
    input logic      clk,
    input logic      rst_n,
    dma2d_if.master  bus
);
    logic [AW-1:0]  addr_q;
    logic [AW-1:0]  row_base;
    logic [AW-1:0]  step_r;
    logic [AW-1:0]  stride_r;
    logic [IFW-1:0] info_q;
    logic           vld_q;
    logic           first_q;
    logic           row_last_q;
    logic           last_q;

    logic           acc;
    logic           adv;
    logic           col_zero;
    logic           col_nxt_zero;
    logic           row_zero;
    logic           row_nxt_zero;
    logic [AW-1:0]  next_row;

    assign bus.start_ready = ~vld_q | (bus.s_ready & last_q);
    assign acc      = bus.start_valid & bus.start_ready;
    assign adv      = vld_q & bus.s_ready & ~last_q;
    assign next_row = row_base + stride_r;

    // Column counter reloads its shadow (size) at each row end; row counter only steps there.
    dma_loop_cnt #(.W(SZW)) u_col (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (acc),
        .load_val (bus.size),
        .dec      (adv & ~col_zero),
        .reload   (adv & col_zero),
        .zero     (col_zero),
        .nxt_zero (col_nxt_zero)
    );

    dma_loop_cnt #(.W(RW)) u_row (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (acc),
        .load_val (bus.rows),
        .dec      (adv & col_zero),
        .reload   (1'b0),
        .zero     (row_zero),
        .nxt_zero (row_nxt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            row_base   <= '0;
            step_r     <= '0;
            stride_r   <= '0;
            info_q     <= '0;
            vld_q      <= 1'b0;
            first_q    <= 1'b0;
            row_last_q <= 1'b0;
            last_q     <= 1'b0;
        end else if (acc) begin
            addr_q     <= bus.base;
            row_base   <= bus.base;
            step_r     <= AW'(bus.step);
            stride_r   <= AW'(bus.row_stride);
            info_q     <= bus.info;
            vld_q      <= 1'b1;
            first_q    <= 1'b1;
            row_last_q <= col_nxt_zero;
            last_q     <= col_nxt_zero & row_nxt_zero;
        end else if (vld_q & bus.s_ready) begin
            if (last_q) begin
                vld_q      <= 1'b0;
                first_q    <= 1'b0;
                row_last_q <= 1'b0;
                last_q     <= 1'b0;
            end else begin
                first_q    <= 1'b0;
                row_last_q <= col_nxt_zero;
                last_q     <= col_nxt_zero & row_nxt_zero;
                if (!col_zero) begin
                    addr_q <= addr_q + step_r;
                end else begin
                    addr_q   <= next_row;
                    row_base <= next_row;
                end
            end
        end
    end

    assign bus.s_addr     = addr_q;
    assign bus.s_info     = info_q;
    assign bus.s_first    = first_q;
    assign bus.s_row_last = row_last_q;
    assign bus.s_last     = last_q;
    assign bus.s_valid    = vld_q;
    assign bus.busy       = vld_q;
endmodule

// File: tb/tb_dma2d.sv
// Directed and randomized bench for dma2d against a nested-loop address model.
module tb_dma2d;
    import dma2d_pkg::*;

    localparam int AW  = AW_DEF;
    localparam int IFW = IFW_DEF;
    localparam int SZW = SZW_DEF;
    localparam int STW = STW_DEF;
    localparam int RW  = RW_DEF;
    localparam int RSW = RSW_DEF;
    localparam int BUDGET = 6000;

    typedef struct {
        logic [AW-1:0]  base;
        logic [SZW-1:0] size;
        logic [STW-1:0] step;
        logic [RW-1:0]  rows;
        logic [RSW-1:0] stride;
        logic [IFW-1:0] info;
    } cmd_t;

    typedef struct {
        logic [AW-1:0]  addr;
        logic [IFW-1:0] info;
        logic           first;
        logic           row_last;
        logic           last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    cmd_t  cmd_q[$];
    beat_t exp_q[$];

    always #5 clk = ~clk;

    dma2d_if #(.AW(AW), .IFW(IFW), .SZW(SZW), .STW(STW), .RW(RW), .RSW(RSW)) bus ();

    dma2d #(.AW(AW), .IFW(IFW), .SZW(SZW), .STW(STW), .RW(RW), .RSW(RSW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every beat of a command, in order, straight from base + r*stride + c*step mod 2^AW.
    function automatic void expand(input cmd_t c);
        for (int r = 0; r <= int'(c.rows); r++) begin
            for (int k = 0; k <= int'(c.size); k++) begin
                beat_t b;
                b.addr     = AW'((int'(c.base) + r * int'(c.stride) + k * int'(c.step)) % (1 << AW));
                b.info     = c.info;
                b.first    = (r == 0) && (k == 0);
                b.row_last = (k == int'(c.size));
                b.last     = (k == int'(c.size)) && (r == int'(c.rows));
                exp_q.push_back(b);
            end
        end
    endfunction

    function automatic cmd_t mk(input int base, input int size, input int step,
                                input int rows, input int stride, input int info);
        cmd_t c;
        c.base   = AW'(base);
        c.size   = SZW'(size);
        c.step   = STW'(step);
        c.rows   = RW'(rows);
        c.stride = RSW'(stride);
        c.info   = IFW'(info);
        return c;
    endfunction

    function automatic cmd_t rnd_cmd();
        return mk($urandom, $urandom_range(0, 5), $urandom, $urandom_range(0, 3), $urandom, $urandom);
    endfunction

    // mode 0: s_ready always 1; mode 1: random with a 5-cycle low window. hs_limit>0 stops early.
    task automatic run(input int mode, input int hs_limit);
        int    cyc = 0;
        int    hs = 0;
        int    stall_left = 0;
        logic  stall_prev = 1'b0;
        beat_t held;
        beat_t e;
        while ((cmd_q.size() != 0 || exp_q.size() != 0) && cyc < BUDGET
               && (hs_limit == 0 || hs < hs_limit)) begin
            if (cmd_q.size() != 0) begin
                bus.start_valid = 1'b1;
                bus.base        = cmd_q[0].base;
                bus.size        = cmd_q[0].size;
                bus.step        = cmd_q[0].step;
                bus.rows        = cmd_q[0].rows;
                bus.row_stride  = cmd_q[0].stride;
                bus.info        = cmd_q[0].info;
            end else begin
                bus.start_valid = 1'b0;
                bus.base        = AW'($urandom);
                bus.size        = SZW'($urandom);
                bus.step        = STW'($urandom);
                bus.rows        = RW'($urandom);
                bus.row_stride  = RSW'($urandom);
                bus.info        = IFW'($urandom);
            end
            if (mode == 0) begin
                bus.s_ready = 1'b1;
            end else begin
                if (cyc == 3) stall_left = 5;
                if (stall_left > 0) begin
                    bus.s_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.s_ready = 1'($urandom_range(0, 1));
                end
            end
            #1;
            if (stall_prev) begin
                chk("stall_addr", 32'(bus.s_addr), 32'(held.addr));
                chk("stall_info", 32'(bus.s_info), 32'(held.info));
                chk("stall_flags", {bus.s_first, bus.s_row_last, bus.s_last},
                    {held.first, held.row_last, held.last});
            end
            chk("s_valid", 32'(bus.s_valid), 32'(exp_q.size() != 0));
            chk("busy", 32'(bus.busy), 32'(exp_q.size() != 0));
            chk("start_ready", 32'(bus.start_ready),
                32'((exp_q.size() == 0) || (bus.s_ready && exp_q[0].last)));
            stall_prev    = bus.s_valid & ~bus.s_ready;
            held.addr     = bus.s_addr;
            held.info     = bus.s_info;
            held.first    = bus.s_first;
            held.row_last = bus.s_row_last;
            held.last     = bus.s_last;
            if (bus.s_valid && bus.s_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("addr", 32'(bus.s_addr), 32'(e.addr));
                chk("info", 32'(bus.s_info), 32'(e.info));
                chk("first", 32'(bus.s_first), 32'(e.first));
                chk("row_last", 32'(bus.s_row_last), 32'(e.row_last));
                chk("last", 32'(bus.s_last), 32'(e.last));
                hs++;
            end
            if (bus.start_valid && bus.start_ready) begin
                expand(cmd_q.pop_front());
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start_valid = 1'b0;
        if (hs_limit == 0) begin
            chk("drained", 32'(exp_q.size() + cmd_q.size()), 32'd0);
            chk("idle_valid", 32'(bus.s_valid), 32'd0);
        end
    endtask

    initial begin
        bus.start_valid = 1'b0;
        bus.s_ready     = 1'b0;
        bus.base        = '0;
        bus.size        = '0;
        bus.step        = '0;
        bus.rows        = '0;
        bus.row_stride  = '0;
        bus.info        = '0;
        #3;
        chk("rst_valid", 32'(bus.s_valid), 32'd0);
        chk("rst_addr", 32'(bus.s_addr), 32'd0);
        chk("rst_info", 32'(bus.s_info), 32'd0);
        chk("rst_flags", {bus.s_first, bus.s_row_last, bus.s_last, bus.busy}, 32'd0);
        chk("rst_start_ready", 32'(bus.start_ready), 32'd1);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cmd_q.push_back(mk(10, 0, 0, 0, 0, 8'h11));
        run(0, 0);
        cmd_q.push_back(mk(0, 3, 2, 0, 0, 8'h22));
        run(0, 0);
        cmd_q.push_back(mk(100, 2, 1, 1, 16, 8'h33));
        run(0, 0);
        cmd_q.push_back(mk(100, 2, 1, 1, 16, 8'h44));
        run(1, 0);
        cmd_q.push_back(mk(0, 3, 2, 0, 0, 8'h55));
        cmd_q.push_back(mk(100, 2, 1, 1, 16, 8'h66));
        run(0, 0);
        cmd_q.push_back(mk(2046, 3, 1, 0, 0, 8'h77));
        run(0, 0);
        cmd_q.push_back(mk(2040, 127, 31, 2, 2047, 8'h88));
        run(1, 0);
        cmd_q.push_back(mk(500, 2, 0, 2, 0, 8'h99));
        run(0, 0);
        for (int i = 0; i < 6; i++) begin
            cmd_q.push_back(rnd_cmd());
            run(1, 0);
        end
        for (int i = 0; i < 3; i++) cmd_q.push_back(rnd_cmd());
        run(1, 0);

        // Reset in the middle of a command, away from a clock edge.
        cmd_q.push_back(mk(300, 7, 3, 3, 64, 8'hAA));
        run(0, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.s_valid), 32'd0);
        chk("mid_rst_addr", 32'(bus.s_addr), 32'd0);
        chk("mid_rst_info", 32'(bus.s_info), 32'd0);
        chk("mid_rst_flags", {bus.s_first, bus.s_row_last, bus.s_last, bus.busy}, 32'd0);
        exp_q.delete();
        cmd_q.delete();
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cmd_q.push_back(mk(1000, 2, 5, 1, 100, 8'hBB));
        run(1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
